crc_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one `crc_gen` engine among `N_REQ` stream requesters. It accepts beats on per-requester valid/ready ports and drives the engine's `din`/`dlast`/`flitEn` inputs. It tracks the engine pipeline latency so that each `crc_out_vld` pulse is returned tagged with the requester id and packet beat count. Grant is locked for a whole packet, because the engine's CRC state is only re-initialised on a `dlast` beat.

---
 rtl/crc_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_crc_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_arbiter.sv
// rtl/crc_arbiter.sv - packet-level round-robin arbiter sharing one crc_gen engine
module crc_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DWIDTH    = 512,
   parameter int CRC_WIDTH = 16,
   parameter int PIPE_LVL  = 0,
   parameter int LEN_W     = 16,
   localparam int ID_W     = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ*DWIDTH-1:0] req_tdata,
   input  logic [N_REQ-1:0]        req_tvalid,
   input  logic [N_REQ-1:0]        req_tlast,
   output logic [N_REQ-1:0]        req_tready,
   output logic [DWIDTH-1:0]       eng_din,
   output logic                    eng_dlast,
   output logic                    eng_flitEn,
   input  logic [CRC_WIDTH-1:0]    eng_crc,
   input  logic                    eng_crc_vld,
   output logic [CRC_WIDTH-1:0]    res_crc,
   output logic [ID_W-1:0]         res_id,
   output logic [LEN_W-1:0]        res_len,
   output logic                    res_vld
);

   // Engine latency from flitEn to crc_out_vld; the tag line has LAT+1 stages
   // because the tag is pushed one cycle before the engine sees the beat.
   localparam int                LAT     = PIPE_LVL + 1;
   localparam logic [LEN_W-1:0]  LEN_MAX = '1;
   localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   sel;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  cnt_inc;
   logic [LEN_W-1:0]  push_len;
   logic              any_valid;
   logic              accept;
   logic              sel_last;
   logic              push;
   logic [DWIDTH-1:0] sel_data;

   logic              tag_v   [0:LAT];
   logic [ID_W-1:0]   tag_id  [0:LAT];
   logic [LEN_W-1:0]  tag_len [0:LAT];

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return ID_W'(s);
   endfunction

   assign any_valid = |req_tvalid;
   assign sel       = (state_q == LOCKED) ? grant_q : pick;
   assign cnt_inc   = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + LEN_ONE;

   // Round-robin pick: first valid requester scanning upward from ptr
   always_comb begin
      pick = ptr_q;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_tvalid[wrap_add(ptr_q, k)]) pick = wrap_add(ptr_q, k);
      end
   end

   // Beat data of the selected requester
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel == ID_W'(i)) sel_data = req_tdata[i*DWIDTH +: DWIDTH];
      end
   end

   // Arbitration state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, ready and tag push; grant stays with the owner until its last beat
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      req_tready = '0;
      push       = 1'b0;
      push_len   = '0;
      if (!rst) begin
         if (state_q == LOCKED) req_tready[grant_q] = 1'b1;
         else if (any_valid)    req_tready[pick]    = 1'b1;
      end
      accept   = req_tvalid[sel] & req_tready[sel];
      sel_last = req_tlast[sel];
      if (accept) begin
         if (sel_last) begin
            push     = 1'b1;
            push_len = (state_q == LOCKED) ? cnt_inc : LEN_ONE;
            ptr_d    = wrap_add(sel, 1);
            state_d  = IDLE;
            cnt_d    = '0;
         end else begin
            state_d  = LOCKED;
            grant_d  = sel;
            cnt_d    = (state_q == LOCKED) ? cnt_inc : LEN_ONE;
         end
      end
   end

   // Registered engine drive; din keeps its last value between accepts
   always_ff @(posedge clk) begin
      if (rst) begin
         eng_flitEn <= 1'b0;
         eng_dlast  <= 1'b0;
         eng_din    <= '0;
      end else begin
         eng_flitEn <= accept;
         eng_dlast  <= accept & sel_last;
         if (accept) eng_din <= sel_data;
      end
   end

   // Tag delay line aligned so the head stage meets the engine result
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= LAT; k++) begin
            tag_v[k]   <= 1'b0;
            tag_id[k]  <= '0;
            tag_len[k] <= '0;
         end
      end else begin
         tag_v[0]   <= push;
         tag_id[0]  <= sel;
         tag_len[0] <= push_len;
         for (int k = 1; k <= LAT; k++) begin
            tag_v[k]   <= tag_v[k-1];
            tag_id[k]  <= tag_id[k-1];
            tag_len[k] <= tag_len[k-1];
         end
      end
   end

   // Result strobe follows the engine; id/len come from the head tag when present
   always_comb begin
      res_vld = eng_crc_vld & ~rst;
      res_crc = '0;
      res_id  = '0;
      res_len = '0;
      if (res_vld) begin
         res_crc = eng_crc;
         if (tag_v[LAT]) begin
            res_id  = tag_id[LAT];
            res_len = tag_len[LAT];
         end
      end
   end

   // An engine result without a pending tag means the latency setup disagrees
   tag_align_a: assert property (@(posedge clk) disable iff (rst) eng_crc_vld |-> tag_v[LAT])
      else $fatal(1, "crc_arbiter: engine result with no pending tag");

endmodule

// File: tb/tb_crc_arbiter.sv
// tb/tb_crc_arbiter.sv - directed self-checking bench for crc_arbiter
module tb_crc_arbiter;

   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int CW  = 16;
   localparam int PL  = 2;
   localparam int LW  = 4;
   localparam int LAT = PL + 1;
   localparam int IDW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N*DW-1:0] req_tdata;
   logic [N-1:0]    req_tvalid;
   logic [N-1:0]    req_tlast;
   logic [N-1:0]    req_tready;
   logic [DW-1:0]   eng_din;
   logic            eng_dlast;
   logic            eng_flitEn;
   logic [CW-1:0]   eng_crc;
   logic            eng_crc_vld;
   logic [CW-1:0]   res_crc;
   logic [IDW-1:0]  res_id;
   logic [LW-1:0]   res_len;
   logic            res_vld;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic          bubble;
   } beat_t;

   typedef struct {
      int            id;
      int            len;
      logic [CW-1:0] crc;
      int            cyc;
   } res_t;

   beat_t srcq [N][$];
   res_t  got_q[$];
   int    acc_id[$];
   int    acc_cyc[$];
   int    last_cyc;
   int    flit_cnt;
   int    onehot_viol;

   crc_arbiter #(
      .N_REQ(N), .DWIDTH(DW), .CRC_WIDTH(CW), .PIPE_LVL(PL), .LEN_W(LW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tlast(req_tlast),
      .req_tready(req_tready),
      .eng_din(eng_din), .eng_dlast(eng_dlast), .eng_flitEn(eng_flitEn),
      .eng_crc(eng_crc), .eng_crc_vld(eng_crc_vld),
      .res_crc(res_crc), .res_id(res_id), .res_len(res_len), .res_vld(res_vld)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [CW-1:0] crc_upd(input logic [CW-1:0] c, input logic [DW-1:0] d);
      logic [CW-1:0] r;
      logic          fb;
      r = c;
      for (int b = DW - 1; b >= 0; b--) begin
         fb = r[CW-1] ^ d[b];
         r  = {r[CW-2:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   // Behavioural crc_gen: CCITT-16, seed FFFF, result LAT cycles after the dlast beat
   logic [CW-1:0] e_state;
   logic [CW-1:0] e_crc_p [LAT];
   logic          e_vld_p [LAT];
   always @(posedge clk) begin
      if (rst) begin
         e_state <= 16'hFFFF;
         for (int k = 0; k < LAT; k++) begin
            e_vld_p[k] <= 1'b0;
            e_crc_p[k] <= '0;
         end
      end else begin
         if (eng_flitEn) e_state <= eng_dlast ? 16'hFFFF : crc_upd(e_state, eng_din);
         e_vld_p[0] <= eng_flitEn & eng_dlast;
         e_crc_p[0] <= crc_upd(e_state, eng_din);
         for (int k = 1; k < LAT; k++) begin
            e_vld_p[k] <= e_vld_p[k-1];
            e_crc_p[k] <= e_crc_p[k-1];
         end
      end
   end
   assign eng_crc_vld = e_vld_p[LAT-1];
   assign eng_crc     = e_crc_p[LAT-1];

   function automatic bit queues_empty();
      for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         req_tvalid[i]           = 1'b0;
         req_tlast[i]            = 1'b0;
         req_tdata[i*DW +: DW]   = '0;
         if (srcq[i].size() > 0 && !srcq[i][0].bubble) begin
            req_tvalid[i]         = 1'b1;
            req_tlast[i]          = srcq[i][0].last;
            req_tdata[i*DW +: DW] = srcq[i][0].data;
         end
      end
   endtask

   task automatic step();
      logic [N-1:0] acc;
      @(negedge clk);
      acc = req_tvalid & req_tready;
      if (!rst && (|req_tvalid) && !$onehot(req_tready)) onehot_viol++;
      if (eng_flitEn) flit_cnt++;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            acc_id.push_back(i);
            acc_cyc.push_back(cyc);
            if (req_tlast[i]) last_cyc = cyc;
         end
      end
      if (res_vld) got_q.push_back('{int'(res_id), int'(res_len), res_crc, cyc});
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (srcq[i].size() > 0 && (acc[i] || srcq[i][0].bubble)) void'(srcq[i].pop_front());
      end
      drive_inputs();
   endtask

   task automatic add_pkt(input int id, input int nbeats, input int gap_at, input int gap_len,
                          input logic [DW-1:0] seed, output logic [CW-1:0] crc);
      beat_t b;
      crc = 16'hFFFF;
      for (int k = 0; k < nbeats; k++) begin
         if (k == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               b.data = '0; b.last = 1'b0; b.bubble = 1'b1;
               srcq[id].push_back(b);
            end
         end
         b.data   = seed + DW'(k * 16'h03B5);
         b.last   = (k == nbeats - 1);
         b.bubble = 1'b0;
         crc      = crc_upd(crc, b.data);
         srcq[id].push_back(b);
      end
   endtask

   task automatic drain(input int n_res, output bit timeout);
      int guard;
      guard = 0;
      while ((got_q.size() < n_res || !queues_empty()) && guard < 300) begin
         step();
         guard++;
      end
      timeout = (guard >= 300);
      repeat (LAT + 3) step();
   endtask

   task automatic clear_logs();
      got_q.delete();
      acc_id.delete();
      acc_cyc.delete();
      flit_cnt    = 0;
      onehot_viol = 0;
      last_cyc    = -1;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      for (int i = 0; i < N; i++) srcq[i].delete();
      drive_inputs();
      step();
      step();
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      req_tvalid = '1;
      req_tlast  = '1;
      req_tdata  = {N{16'hBEEF}};
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (req_tready !== 4'b0000) $display("FAIL reset_tready: got %b expected 0000", req_tready); else n_pass++;
      n_checks++; if (eng_flitEn !== 1'b0) $display("FAIL reset_flitEn: got %b expected 0", eng_flitEn); else n_pass++;
      n_checks++; if (eng_dlast !== 1'b0) $display("FAIL reset_dlast: got %b expected 0", eng_dlast); else n_pass++;
      n_checks++; if (eng_din !== 16'h0) $display("FAIL reset_din: got %h expected 0000", eng_din); else n_pass++;
      n_checks++; if (res_vld !== 1'b0) $display("FAIL reset_res_vld: got %b expected 0", res_vld); else n_pass++;
      n_checks++; if (res_id !== 2'd0 || res_len !== 4'd0 || res_crc !== 16'h0)
         $display("FAIL reset_res_fields: got id %0d len %0d crc %h expected 0 0 0000", res_id, res_len, res_crc); else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_logs();
      drive_inputs();
      step();
      n_checks++; if (req_tready !== 4'b0000) $display("FAIL idle_tready: got %b expected 0000", req_tready); else n_pass++;
      req_tvalid = 4'b0100;
      #1;
      n_checks++; if (req_tready !== 4'b0100) $display("FAIL idle_pick: got %b expected 0100", req_tready); else n_pass++;
      req_tvalid = 4'b1010;
      #1;
      n_checks++; if (req_tready !== 4'b0010) $display("FAIL idle_pick_rr: got %b expected 0010", req_tready); else n_pass++;
      drive_inputs();
      step();
      n_checks++; if (acc_id.size() !== 0) $display("FAIL idle_no_accept: got %0d accepts expected 0", acc_id.size()); else n_pass++;
   endtask

   task automatic test_single();
      logic [CW-1:0] c;
      bit            to;
      clear_logs();
      add_pkt(2, 3, -1, 0, 16'h1234, c);
      drive_inputs();
      drain(1, to);
      n_checks++; if (to) $display("FAIL single_timeout: got timeout expected result"); else n_pass++;
      n_checks++; if (got_q.size() !== 1) $display("FAIL single_count: got %0d expected 1", got_q.size()); else n_pass++;
      if (got_q.size() >= 1) begin
         n_checks++; if (got_q[0].id !== 2) $display("FAIL single_id: got %0d expected 2", got_q[0].id); else n_pass++;
         n_checks++; if (got_q[0].len !== 3) $display("FAIL single_len: got %0d expected 3", got_q[0].len); else n_pass++;
         n_checks++; if (got_q[0].crc !== c) $display("FAIL single_crc: got %h expected %h", got_q[0].crc, c); else n_pass++;
         n_checks++; if (got_q[0].cyc !== last_cyc + PL + 2)
            $display("FAIL single_latency: got cycle %0d expected %0d", got_q[0].cyc, last_cyc + PL + 2); else n_pass++;
      end
   endtask

   task automatic test_fairness();
      logic [CW-1:0] c;
      logic [CW-1:0] exp_crc [8];
      bit            to;
      reset_pulse();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) begin
            add_pkt(i, 2, -1, 0, DW'(16'h4000 + r * 16'h100 + i * 16'h10), c);
            exp_crc[r*N+i] = c;
         end
      end
      drive_inputs();
      drain(8, to);
      n_checks++; if (to) $display("FAIL fair_timeout: got timeout expected 8 results"); else n_pass++;
      n_checks++; if (onehot_viol !== 0) $display("FAIL fair_onehot: got %0d bad cycles expected 0", onehot_viol); else n_pass++;
      n_checks++; if (acc_id.size() !== 16) $display("FAIL fair_beats: got %0d expected 16", acc_id.size()); else n_pass++;
      if (acc_id.size() == 16) begin
         for (int k = 0; k < 16; k++) begin
            n_checks++; if (acc_id[k] !== (k / 2) % N) $display("FAIL fair_order[%0d]: got %0d expected %0d", k, acc_id[k], (k / 2) % N); else n_pass++;
         end
         n_checks++; if (acc_cyc[15] - acc_cyc[0] !== 15) $display("FAIL fair_no_bubble: got span %0d expected 15", acc_cyc[15] - acc_cyc[0]); else n_pass++;
      end
      n_checks++; if (got_q.size() !== 8) $display("FAIL fair_results: got %0d expected 8", got_q.size()); else n_pass++;
      for (int k = 0; k < 8 && k < got_q.size(); k++) begin
         n_checks++; if (got_q[k].id !== k % N || got_q[k].len !== 2 || got_q[k].crc !== exp_crc[k])
            $display("FAIL fair_res[%0d]: got id %0d len %0d crc %h expected id %0d len 2 crc %h",
                     k, got_q[k].id, got_q[k].len, got_q[k].crc, k % N, exp_crc[k]); else n_pass++;
      end
   endtask

   task automatic test_packet_lock();
      logic [CW-1:0] c1, c0, c3;
      bit            to;
      int            exp_ord [7];
      exp_ord = '{1, 1, 1, 1, 1, 3, 0};
      clear_logs();
      add_pkt(1, 5, 2, 5, 16'h7100, c1);
      drive_inputs();
      step();
      add_pkt(0, 1, -1, 0, 16'h7000, c0);
      add_pkt(3, 1, -1, 0, 16'h7300, c3);
      drive_inputs();
      drain(3, to);
      n_checks++; if (to) $display("FAIL lock_timeout: got timeout expected 3 results"); else n_pass++;
      n_checks++; if (acc_id.size() !== 7) $display("FAIL lock_beats: got %0d expected 7", acc_id.size()); else n_pass++;
      if (acc_id.size() == 7) begin
         for (int k = 0; k < 7; k++) begin
            n_checks++; if (acc_id[k] !== exp_ord[k]) $display("FAIL lock_order[%0d]: got %0d expected %0d", k, acc_id[k], exp_ord[k]); else n_pass++;
         end
         n_checks++; if (acc_cyc[2] - acc_cyc[1] !== 6) $display("FAIL lock_gap: got %0d expected 6", acc_cyc[2] - acc_cyc[1]); else n_pass++;
      end
      n_checks++; if (flit_cnt !== 7) $display("FAIL lock_flitEn: got %0d strobes expected 7", flit_cnt); else n_pass++;
      n_checks++; if (got_q.size() !== 3) $display("FAIL lock_results: got %0d expected 3", got_q.size()); else n_pass++;
      if (got_q.size() == 3) begin
         n_checks++; if (got_q[0].id !== 1 || got_q[0].len !== 5 || got_q[0].crc !== c1)
            $display("FAIL lock_res_owner: got id %0d len %0d crc %h expected 1 5 %h", got_q[0].id, got_q[0].len, got_q[0].crc, c1); else n_pass++;
         n_checks++; if (got_q[1].id !== 3 || got_q[1].len !== 1 || got_q[1].crc !== c3)
            $display("FAIL lock_res_r3: got id %0d len %0d crc %h expected 3 1 %h", got_q[1].id, got_q[1].len, got_q[1].crc, c3); else n_pass++;
         n_checks++; if (got_q[2].id !== 0 || got_q[2].len !== 1 || got_q[2].crc !== c0)
            $display("FAIL lock_res_r0: got id %0d len %0d crc %h expected 0 1 %h", got_q[2].id, got_q[2].len, got_q[2].crc, c0); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [CW-1:0] c;
      logic [CW-1:0] exp_crc [8];
      bit            to;
      reset_pulse();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) begin
            add_pkt(i, 1, -1, 0, DW'(16'h9000 + r * 16'h80 + i * 16'h11), c);
            exp_crc[r*N+i] = c;
         end
      end
      drive_inputs();
      drain(8, to);
      n_checks++; if (to) $display("FAIL b2b_timeout: got timeout expected 8 results"); else n_pass++;
      n_checks++; if (acc_id.size() !== 8 || got_q.size() !== 8)
         $display("FAIL b2b_counts: got %0d beats %0d results expected 8 8", acc_id.size(), got_q.size()); else n_pass++;
      if (acc_id.size() == 8 && got_q.size() == 8) begin
         for (int k = 0; k < 8; k++) begin
            n_checks++; if (acc_id[k] !== k % N || acc_cyc[k] !== acc_cyc[0] + k)
               $display("FAIL b2b_accept[%0d]: got id %0d cycle %0d expected id %0d cycle %0d", k, acc_id[k], acc_cyc[k], k % N, acc_cyc[0] + k); else n_pass++;
            n_checks++; if (got_q[k].id !== k % N || got_q[k].len !== 1 || got_q[k].crc !== exp_crc[k] || got_q[k].cyc !== acc_cyc[k] + PL + 2)
               $display("FAIL b2b_res[%0d]: got id %0d len %0d crc %h cycle %0d expected id %0d len 1 crc %h cycle %0d",
                        k, got_q[k].id, got_q[k].len, got_q[k].crc, got_q[k].cyc, k % N, exp_crc[k], acc_cyc[k] + PL + 2); else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [CW-1:0] c1, c3, c0;
      bit            to;
      clear_logs();
      add_pkt(1, 1, -1, 0, 16'h5100, c1);
      drive_inputs();
      drain(1, to);
      n_checks++; if (to || got_q.size() !== 1) $display("FAIL rstmid_pre: got %0d results expected 1", got_q.size()); else n_pass++;
      clear_logs();
      add_pkt(3, 4, -1, 0, 16'h5300, c3);
      drive_inputs();
      step();
      rst = 1'b1;
      for (int i = 0; i < N; i++) srcq[i].delete();
      drive_inputs();
      repeat (3) step();
      n_checks++; if (acc_id.size() !== 1) $display("FAIL rstmid_accepts: got %0d expected 1", acc_id.size()); else n_pass++;
      n_checks++; if (got_q.size() !== 0) $display("FAIL rstmid_no_result: got %0d expected 0", got_q.size()); else n_pass++;
      rst = 1'b0;
      clear_logs();
      add_pkt(3, 2, -1, 0, 16'h6300, c3);
      add_pkt(0, 2, -1, 0, 16'h6000, c0);
      drive_inputs();
      drain(2, to);
      n_checks++; if (to || got_q.size() !== 2) $display("FAIL rstmid_post_count: got %0d expected 2", got_q.size()); else n_pass++;
      if (got_q.size() == 2) begin
         n_checks++; if (got_q[0].id !== 0 || got_q[0].len !== 2 || got_q[0].crc !== c0)
            $display("FAIL rstmid_first: got id %0d len %0d crc %h expected 0 2 %h", got_q[0].id, got_q[0].len, got_q[0].crc, c0); else n_pass++;
         n_checks++; if (got_q[1].id !== 3 || got_q[1].len !== 2 || got_q[1].crc !== c3)
            $display("FAIL rstmid_second: got id %0d len %0d crc %h expected 3 2 %h", got_q[1].id, got_q[1].len, got_q[1].crc, c3); else n_pass++;
      end
   endtask

   task automatic test_saturation();
      logic [CW-1:0] c14, c15, c20;
      bit            to;
      clear_logs();
      add_pkt(1, 14, -1, 0, 16'h2100, c14);
      add_pkt(2, 15, -1, 0, 16'h2200, c15);
      add_pkt(3, 20, -1, 0, 16'h2300, c20);
      drive_inputs();
      drain(3, to);
      n_checks++; if (to || got_q.size() !== 3) $display("FAIL sat_count: got %0d expected 3", got_q.size()); else n_pass++;
      if (got_q.size() == 3) begin
         n_checks++; if (got_q[0].id !== 1 || got_q[0].len !== 14 || got_q[0].crc !== c14)
            $display("FAIL sat_len14: got id %0d len %0d crc %h expected 1 14 %h", got_q[0].id, got_q[0].len, got_q[0].crc, c14); else n_pass++;
         n_checks++; if (got_q[1].id !== 2 || got_q[1].len !== 15 || got_q[1].crc !== c15)
            $display("FAIL sat_len15: got id %0d len %0d crc %h expected 2 15 %h", got_q[1].id, got_q[1].len, got_q[1].crc, c15); else n_pass++;
         n_checks++; if (got_q[2].id !== 3 || got_q[2].len !== 15 || got_q[2].crc !== c20)
            $display("FAIL sat_len20: got id %0d len %0d crc %h expected 3 15 %h", got_q[2].id, got_q[2].len, got_q[2].crc, c20); else n_pass++;
      end
   endtask

   initial begin
      req_tdata  = '0;
      req_tvalid = '0;
      req_tlast  = '0;
      clear_logs();
      test_reset();
      test_single();
      test_fairness();
      test_packet_lock();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
